seq_prop_checker: RTL and testbench
===================================

Name: seq_prop_checker

Overview:
- Synthesizable concurrent-property checker that sits directly downstream of the a/b stimulus stage. It consumes the same clk-sampled a and b signals.
- It evaluates the temporal property "a |-> ##[MIN_DLY:MAX_DLY] b" in hardware, one attempt at a time.
- It emits per-attempt pass/fail pulses, saturating pass/fail/drop counters, and a sticky timestamp of the first failure.
- Used in benches and emulation, where simulator assertions are unavailable, to score the random a/b stream.

Parameters:
- MIN_DLY, 1: earliest cycle after the antecedent at which b satisfies the property. Legal range is 1..MAX_DLY.
- MAX_DLY, 4: last cycle after the antecedent at which b satisfies the property. Legal range is 1..255.
- CNT_W, 16: width of pass_cnt, fail_cnt and drop_cnt.

Ports:
- clk  in  1  sampling clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  checker enable.
- a  in  1  antecedent.
- b  in  1  consequent.
- pass  out  1  one-cycle pulse: attempt succeeded.
- fail  out  1  one-cycle pulse: attempt timed out.
- busy  out  1  high while an attempt is pending (state WAIT).
- pass_cnt  out  CNT_W  saturating count of passes.
- fail_cnt  out  CNT_W  saturating count of failures.
- drop_cnt  out  CNT_W  saturating count of antecedents ignored because an attempt was pending.
- first_fail_vld  out  1  sticky; set on the first failure.
- first_fail_time  out  32  cyc value at the decision cycle of the first failure.

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high, sampled on posedge clk.
- On reset: every output and internal register is 0, state=IDLE, cyc=0. The cycle after rst deasserts has cyc=0.
- cyc: internal 32-bit free-running cycle counter, +1 per clock. Wraps from 2^32-1 to 0.
- FSM states: IDLE and WAIT. Internal delay counter d is 8 bits.
- IDLE:
  - If en & a, go to WAIT with d=1 on the next cycle. The cycle where a was sampled is trigger cycle T.
  - If en is low, a is ignored and not counted.
- WAIT, at cycle T+d:
  - If b & (d >= MIN_DLY): pass decision.
  - Else if d == MAX_DLY: fail decision.
  - Else: d <= d+1 and stay in WAIT.
  - b with d < MIN_DLY is ignored. It neither passes nor fails the attempt.
  - b in cycle T itself (d=0) never counts.
- Decision cycle:
  - pass/fail is registered and pulses high for exactly one cycle, in the cycle after the decision.
  - The matching counter increments in that same cycle.
  - On the first fail only: first_fail_vld <= 1 and first_fail_time <= cyc of the decision cycle.
  - Both fields hold until rst.
- Re-arm: on the decision cycle, if en & a, go straight back to WAIT with d=1 (this cycle becomes the new T). Otherwise go to IDLE. No dead cycle between attempts.
- Overlap: en & a in WAIT on a non-decision cycle increments drop_cnt by 1 per such cycle. The pending attempt is unaffected.
- en low in WAIT: abort to IDLE next cycle. No pass/fail pulse, no counter change.
- Counters saturate at 2^CNT_W-1 and never wrap.
- busy is the registered state: high exactly while state==WAIT.
- Simultaneous-event priority: rst > en-abort > decision(pass > fail) > drop.
- rst mid-WAIT: attempt discarded. All outputs are 0 in the next cycle, including sticky fields.

Test Plan (MIN_DLY=1, MAX_DLY=4, CNT_W=16 unless stated):
- a=1 at cyc 5 only, b=1 at cyc 7 -> pass=1 at cyc 8 only, pass_cnt=1, fail=0, busy high cyc 6-7 and low at cyc 8.
- a=1 at cyc 10, b=0 thereafter -> fail=1 at cyc 15, fail_cnt=1, first_fail_vld=1, first_fail_time=14. A second timeout leaves first_fail_time at 14.
- a=b=1 at cyc 20, b=0 after -> fail at cyc 25 (d=0 b ignored). With MIN_DLY=2: b at T+1 only -> fail at T+5.
- a at T, a at T+2, b at T+3 -> pass at T+4, drop_cnt=1. Then a at T+3 as well -> re-arm: busy stays high at T+4 and a second attempt starts.
- a at T, en=0 at T+2 -> no pass/fail ever, busy=0 at T+3, counters unchanged. Then rst=1 mid-WAIT -> all outputs 0 next cycle.
- CNT_W=2, 5 passing attempts -> pass_cnt sequence 1,2,3,3,3. Force cyc near 2^32-1 via long run or force -> wraps to 0 with no glitch on outputs.

Source files
------------

// File: rtl/seq_prop_checker.sv
// Hardware checker for the property "a |-> ##[MIN_DLY:MAX_DLY] b", one attempt at a time.
// It produces pass/fail pulses, saturating pass/fail/drop counters and the cycle stamp of the first failure.
module seq_prop_checker #(
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  output logic             pass,
  output logic             fail,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             first_fail_vld,
  output logic [31:0]      first_fail_time
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0]       MIN_D   = 8'(MIN_DLY);
  localparam logic [7:0]       MAX_D   = 8'(MAX_DLY);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [7:0]       d_q, d_d;
  logic [31:0]      cyc_q, cyc_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             ffv_q, ffv_d;
  logic [31:0]      fft_q, fft_d;
  logic             trig;
  logic             decided;

  assign trig = en & a;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    d_d        = d_q;
    cyc_d      = cyc_q + 32'd1;
    pass_d     = 1'b0;
    fail_d     = 1'b0;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ffv_d      = ffv_q;
    fft_d      = fft_q;
    decided    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_WAIT;
          d_d     = 8'd1;
        end
      end
      S_WAIT: begin
        if (!en) begin
          // Abort outranks any decision this cycle: the attempt vanishes without a pulse.
          state_d = S_IDLE;
          d_d     = 8'd0;
        end else if (b && (d_q >= MIN_D)) begin
          decided = 1'b1;
          pass_d  = 1'b1;
          if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
        end else if (d_q == MAX_D) begin
          decided = 1'b1;
          fail_d  = 1'b1;
          if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            fft_d = cyc_q;
          end
        end else begin
          d_d = d_q + 8'd1;
          if (trig && (drop_cnt_q != CNT_MAX)) drop_cnt_d = drop_cnt_q + 1'b1;
        end

        // A decision cycle may itself be the trigger of the next attempt.
        if (decided) begin
          if (trig) begin
            state_d = S_WAIT;
            d_d     = 8'd1;
          end else begin
            state_d = S_IDLE;
            d_d     = 8'd0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        d_d     = 8'd0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      d_q        <= 8'd0;
      cyc_q      <= 32'd0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      drop_cnt_q <= '0;
      ffv_q      <= 1'b0;
      fft_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      cyc_q      <= cyc_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ffv_q      <= ffv_d;
      fft_q      <= fft_d;
    end
  end

  assign pass            = pass_q;
  assign fail            = fail_q;
  assign busy            = (state_q == S_WAIT);
  assign pass_cnt        = pass_cnt_q;
  assign fail_cnt        = fail_cnt_q;
  assign drop_cnt        = drop_cnt_q;
  assign first_fail_vld  = ffv_q;
  assign first_fail_time = fft_q;

endmodule

// File: tb/tb_seq_prop_checker.sv
// Directed bench for seq_prop_checker: a scoreboard of hand-computed pass/fail events on the default instance,
// plus direct checks on a MIN_DLY=2 instance and a CNT_W=2 instance.
module tb_seq_prop_checker;

  logic clk = 1'b0;
  logic rst;
  int   tb_cyc;

  // Default instance (MIN_DLY=1, MAX_DLY=4, CNT_W=16)
  logic        en, a, b;
  logic        pass, fail, busy, ffv;
  logic [15:0] pass_cnt, fail_cnt, drop_cnt;
  logic [31:0] fft;

  // MIN_DLY=2 instance
  logic        en2, a2, b2;
  logic        pass2, fail2, busy2, ffv2;
  logic [15:0] pass_cnt2, fail_cnt2, drop_cnt2;
  logic [31:0] fft2;

  // CNT_W=2 instance
  logic        en3, a3, b3;
  logic        pass3, fail3, busy3, ffv3;
  logic [1:0]  pass_cnt3, fail_cnt3, drop_cnt3;
  logic [31:0] fft3;

  seq_prop_checker #(.MIN_DLY(1), .MAX_DLY(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .pass(pass), .fail(fail), .busy(busy),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .drop_cnt(drop_cnt),
    .first_fail_vld(ffv), .first_fail_time(fft)
  );

  seq_prop_checker #(.MIN_DLY(2), .MAX_DLY(4), .CNT_W(16)) u_min2 (
    .clk(clk), .rst(rst), .en(en2), .a(a2), .b(b2),
    .pass(pass2), .fail(fail2), .busy(busy2),
    .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .drop_cnt(drop_cnt2),
    .first_fail_vld(ffv2), .first_fail_time(fft2)
  );

  seq_prop_checker #(.MIN_DLY(1), .MAX_DLY(4), .CNT_W(2)) u_cw2 (
    .clk(clk), .rst(rst), .en(en3), .a(a3), .b(b3),
    .pass(pass3), .fail(fail3), .busy(busy3),
    .pass_cnt(pass_cnt3), .fail_cnt(fail_cnt3), .drop_cnt(drop_cnt3),
    .first_fail_vld(ffv3), .first_fail_time(fft3)
  );

  always #5 clk = ~clk;

  // Bench timebase: cycle 0 is the first cycle after the reset-sampling edge.
  always @(posedge clk) tb_cyc <= rst ? 0 : tb_cyc + 1;

  typedef struct {
    logic        is_pass;
    int          cyc;
    logic [15:0] pc;
    logic [15:0] fc;
    logic [15:0] dc;
    logic        ffv;
    logic [31:0] fft;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, tb_cyc, act, exp);
    end
  endtask

  task automatic push(input logic is_pass, input int cyc, input logic [15:0] pc, input logic [15:0] fc,
                      input logic [15:0] dc, input logic ffv_e, input logic [31:0] fft_e);
    exp_t e;
    e.is_pass = is_pass; e.cyc = cyc; e.pc = pc; e.fc = fc; e.dc = dc; e.ffv = ffv_e; e.fft = fft_e;
    sb_q.push_back(e);
  endtask

  // Monitor: every pass/fail pulse of the default instance must match the next expected event.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (pass || fail)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, pass, fail}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_pass",  {31'd0, pass}, {31'd0, e.is_pass});
        check("pulse_fail",  {31'd0, fail}, {31'd0, !e.is_pass});
        check("pulse_cycle", tb_cyc, e.cyc);
        check("pulse_pass_cnt", {16'd0, pass_cnt}, {16'd0, e.pc});
        check("pulse_fail_cnt", {16'd0, fail_cnt}, {16'd0, e.fc});
        check("pulse_drop_cnt", {16'd0, drop_cnt}, {16'd0, e.dc});
        check("pulse_ffv", {31'd0, ffv}, {31'd0, e.ffv});
        check("pulse_fft", fft, e.fft);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int n);
    while (tb_cyc < n) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check({tag, "_fail"}, {31'd0, fail}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_pass_cnt"}, {16'd0, pass_cnt}, 32'd0);
    check({tag, "_fail_cnt"}, {16'd0, fail_cnt}, 32'd0);
    check({tag, "_drop_cnt"}, {16'd0, drop_cnt}, 32'd0);
    check({tag, "_ffv"}, {31'd0, ffv}, 32'd0);
    check({tag, "_fft"}, fft, 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [1:0] cw2_exp [5];
    cw2_exp[0] = 2'd1; cw2_exp[1] = 2'd2; cw2_exp[2] = 2'd3; cw2_exp[3] = 2'd3; cw2_exp[4] = 2'd3;

    rst = 1'b1;
    en = 1'b1; a = 1'b0; b = 1'b0;
    en2 = 1'b1; a2 = 1'b0; b2 = 1'b0;
    en3 = 1'b1; a3 = 1'b0; b3 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Simple pass: a@5, b@7 -> pass pulse @8
    run_to(5); a = 1'b1;
    push(1'b1, 8, 16'd1, 16'd0, 16'd0, 1'b0, 32'd0);
    tick(); a = 1'b0; check("s1_busy6", {31'd0, busy}, 32'd1);
    tick(); b = 1'b1; check("s1_busy7", {31'd0, busy}, 32'd1);
    tick(); b = 1'b0; check("s1_busy8", {31'd0, busy}, 32'd0);

    // Timeout: a@10 -> decision @14, fail pulse @15, first failure stamped 14
    run_to(10); a = 1'b1;
    push(1'b0, 15, 16'd1, 16'd1, 16'd0, 1'b1, 32'd14);
    tick(); a = 1'b0;
    run_to(15);
    check("s2_ffv", {31'd0, ffv}, 32'd1);
    check("s2_fft", fft, 32'd14);

    // a=b=1 @20: b in the trigger cycle is ignored -> fail @25, stamp stays 14
    run_to(20); a = 1'b1; b = 1'b1;
    push(1'b0, 25, 16'd1, 16'd2, 16'd0, 1'b1, 32'd14);
    tick(); a = 1'b0; b = 1'b0;
    run_to(26);
    check("s3_fft_sticky", fft, 32'd14);

    // Overlap drop and re-arm: a@30, a@32, a&b@33 -> pass@34 (drop 1), second attempt b@35 -> pass@36
    run_to(30); a = 1'b1;
    push(1'b1, 34, 16'd2, 16'd2, 16'd1, 1'b1, 32'd14);
    tick(); a = 1'b0;
    tick(); a = 1'b1;
    tick(); a = 1'b1; b = 1'b1;
    push(1'b1, 36, 16'd3, 16'd2, 16'd1, 1'b1, 32'd14);
    tick(); a = 1'b0; b = 1'b0; check("s4_rearm_busy34", {31'd0, busy}, 32'd1);
    tick(); b = 1'b1;
    tick(); b = 1'b0; check("s4_busy36", {31'd0, busy}, 32'd0);
    check("s4_drop_cnt", {16'd0, drop_cnt}, 32'd1);

    // Abort: a@40, en=0 with b=1 @42 -> no pulse, busy low @43; a with en=0 @44 ignored
    run_to(40); a = 1'b1;
    tick(); a = 1'b0;
    tick(); en = 1'b0; b = 1'b1;
    tick(); en = 1'b1; b = 1'b0; check("s5_abort_busy43", {31'd0, busy}, 32'd0);
    tick(); en = 1'b0; a = 1'b1;
    tick(); en = 1'b1; a = 1'b0; check("s5_en_low_busy45", {31'd0, busy}, 32'd0);
    run_to(48);
    check("s5_pass_cnt", {16'd0, pass_cnt}, 32'd3);
    check("s5_fail_cnt", {16'd0, fail_cnt}, 32'd2);
    check("s5_drop_cnt", {16'd0, drop_cnt}, 32'd1);

    // Reset mid-WAIT: a@50, rst@52 -> everything zero, sticky fields included
    run_to(50); a = 1'b1;
    tick(); a = 1'b0;
    tick(); rst = 1'b1;
    tick();
    check_all_zero("midwait_rst");
    rst = 1'b0;

    // Cycle counter wrap: trigger @FFFF_FFFE -> decision four cycles later at cyc 2
    run_to(3);
    force u_dut.cyc_q = 32'hFFFF_FFFE;
    a = 1'b1;
    #1 release u_dut.cyc_q;
    push(1'b0, 8, 16'd0, 16'd1, 16'd0, 1'b1, 32'd2);
    tick(); a = 1'b0;
    run_to(9);
    check("wrap_fft", fft, 32'd2);

    // MIN_DLY=2: b at T+1 only -> fail at T+5; b at T+2 -> pass at T+3
    run_to(12); a2 = 1'b1;
    tick(); a2 = 1'b0; b2 = 1'b1;
    tick(); b2 = 1'b0;
    run_to(16); check("min2_no_fail16", {31'd0, fail2}, 32'd0);
    check("min2_no_pass16", {31'd0, pass2}, 32'd0);
    tick(); check("min2_fail17", {31'd0, fail2}, 32'd1);
    check("min2_fail_cnt", {16'd0, fail_cnt2}, 32'd1);
    check("min2_pass_cnt0", {16'd0, pass_cnt2}, 32'd0);
    tick(); check("min2_fail_width", {31'd0, fail2}, 32'd0);
    run_to(20); a2 = 1'b1;
    tick(); a2 = 1'b0;
    tick(); b2 = 1'b1; check("min2_pass22", {31'd0, pass2}, 32'd0);
    tick(); b2 = 1'b0; check("min2_pass23", {31'd0, pass2}, 32'd1);
    check("min2_pass_cnt", {16'd0, pass_cnt2}, 32'd1);

    // CNT_W=2: five back-to-back passes saturate at 3
    run_to(30);
    for (int i = 0; i < 7; i++) begin
      a3 = (i < 5);
      b3 = (i < 6);
      if (i >= 2) begin
        check($sformatf("cw2_pass_cnt_%0d", i - 1), {30'd0, pass_cnt3}, {30'd0, cw2_exp[i-2]});
        check($sformatf("cw2_pass_%0d", i - 1), {31'd0, pass3}, 32'd1);
      end
      tick();
    end
    a3 = 1'b0; b3 = 1'b0;
    check("cw2_busy_after", {31'd0, busy3}, 32'd0);
    check("cw2_pass_done", {31'd0, pass3}, 32'd0);
    check("cw2_pass_cnt_hold", {30'd0, pass_cnt3}, 32'd3);

    run_to(45);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
